// File: rtl/sa_stream_ctrl_pkg.sv
// Shared types and helpers for the systolic-array stream controller.
package sa_pkg;

  // Controller job phases.
  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LOAD_W,
    RUN,
    SEND
  } saState_e;

  // Address width for an N-entry memory (at least one bit).
  function automatic int unsigned addrWidth(input int unsigned n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Fixed-depth delay chain for one valid/address pair of the array skew.
module sa_skew_line
  import sa_pkg::*;
#(
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inValid,
  input  logic [ADDR_W-1:0] inAddr,
  output logic              outValid,
  output logic [ADDR_W-1:0] outAddr
);

  logic [DEPTH-1:0]             validPipe;
  logic [DEPTH-1:0][ADDR_W-1:0] addrPipe;
  logic [DEPTH:0]               validNext;
  logic [DEPTH:0][ADDR_W-1:0]   addrNext;

  // New sample enters at the bottom; the top element is the delayed output.
  assign validNext = {validPipe, inValid};
  assign addrNext  = {addrPipe, inAddr};
  assign outValid  = validNext[DEPTH];
  assign outAddr   = addrNext[DEPTH];

  // Shift by one stage per cycle; abort empties the chain.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      validPipe <= '0;
      addrPipe  <= '0;
    end else begin
      validPipe <= validNext[DEPTH-1:0];
      addrPipe  <= addrNext[DEPTH-1:0];
    end
  end

endmodule

// File: rtl/sa_stream_ctrl.sv
// Job sequencer for an NxN systolic array: stream in, load weights, run, stream out.
module sa_stream_ctrl
  import sa_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned ARRAY_LAT  = 8,
  parameter int unsigned ADDR_W     = addrWidth(ARRAY_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         interrupt,
  input  logic                         reuse_weights,
  input  logic                         s_tvalid,
  input  logic                         s_tlast,
  output logic                         s_tready,
  input  logic                         m_tready,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  output logic                         fill_we,
  output logic [ADDR_W-1:0]            abc_waddr,
  output logic                         load_w,
  output logic [ADDR_W-1:0]            c_raddr,
  output logic [ARRAY_SIZE-1:0]        ab_valid,
  output logic [ARRAY_SIZE*ADDR_W-1:0] ab_raddr,
  output logic [ARRAY_SIZE-1:0]        yz_we,
  output logic [ARRAY_SIZE*ADDR_W-1:0] yz_waddr,
  output logic [ADDR_W-1:0]            yz_raddr,
  output logic                         busy,
  output logic                         done,
  output logic                         err_tlast
);

  localparam int unsigned RUN_LEN = ARRAY_LAT + 2 * ARRAY_SIZE - 1;
  localparam int unsigned CNT_W   = $clog2(RUN_LEN + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ARRAY_SIZE - 1);

  saState_e          state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cntInc;
  logic [ADDR_W-1:0] beatIdx;
  logic [ADDR_W-1:0] sendIdx;
  logic              wloadOk;
  logic              reuseReg;
  logic              abValid0;
  logic [ADDR_W-1:0] abAddr0;
  logic              yzWe0;
  logic [ADDR_W-1:0] yzAddr0;
  logic              flush;
  logic              beatAcc;
  logic              lastBeat;
  logic              sendHs;
  logic              yzIn;
  logic [CNT_W-1:0]  yzOff;

  assign cntInc   = cnt + CNT_W'(1);
  assign flush    = interrupt && (state != IDLE);
  assign beatAcc  = s_tready && s_tvalid;
  assign lastBeat = (beatIdx == LAST_IDX);
  assign sendHs   = m_tvalid && m_tready;
  assign yzIn     = (cntInc >= CNT_W'(ARRAY_LAT)) && (cntInc < CNT_W'(ARRAY_LAT + ARRAY_SIZE));
  assign yzOff    = cntInc - CNT_W'(ARRAY_LAT);

  // s_tready is high exactly in FILL, so an accepted beat is the write strobe.
  assign fill_we   = beatAcc;
  assign abc_waddr = beatIdx;

  // Read address leads the output by one cycle and holds through a stall.
  assign yz_raddr = (sendHs && !m_tlast) ? sendIdx + ADDR_W'(1) : sendIdx;

  // Job FSM with registered strobes; line-0/column-0 sequences are precomputed one cycle ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      beatIdx   <= '0;
      sendIdx   <= '0;
      wloadOk   <= 1'b0;
      reuseReg  <= 1'b0;
      abValid0  <= 1'b0;
      abAddr0   <= '0;
      yzWe0     <= 1'b0;
      yzAddr0   <= '0;
      s_tready  <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      load_w    <= 1'b0;
      c_raddr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_tlast <= 1'b0;
    end else if (flush) begin
      state    <= IDLE;
      cnt      <= '0;
      beatIdx  <= '0;
      sendIdx  <= '0;
      wloadOk  <= 1'b0;
      abValid0 <= 1'b0;
      abAddr0  <= '0;
      yzWe0    <= 1'b0;
      yzAddr0  <= '0;
      s_tready <= 1'b0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      load_w   <= 1'b0;
      c_raddr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FILL;
            busy      <= 1'b1;
            s_tready  <= 1'b1;
            beatIdx   <= '0;
            reuseReg  <= reuse_weights;
            err_tlast <= 1'b0;
          end
        end
        FILL: begin
          if (beatAcc) begin
            if (s_tlast != lastBeat) begin
              err_tlast <= 1'b1;
            end
            if (lastBeat) begin
              beatIdx  <= '0;
              s_tready <= 1'b0;
              cnt      <= '0;
              if (reuseReg && wloadOk) begin
                state    <= RUN;
                abValid0 <= 1'b1;
                abAddr0  <= '0;
                yzWe0    <= (ARRAY_LAT == 0);
                yzAddr0  <= '0;
              end else begin
                state   <= LOAD_W;
                load_w  <= 1'b1;
                c_raddr <= '0;
              end
            end else begin
              beatIdx <= beatIdx + ADDR_W'(1);
            end
          end
        end
        LOAD_W: begin
          if (cnt == CNT_W'(ARRAY_SIZE - 1)) begin
            state    <= RUN;
            cnt      <= '0;
            load_w   <= 1'b0;
            c_raddr  <= '0;
            wloadOk  <= 1'b1;
            abValid0 <= 1'b1;
            abAddr0  <= '0;
            yzWe0    <= (ARRAY_LAT == 0);
            yzAddr0  <= '0;
          end else begin
            cnt     <= cntInc;
            c_raddr <= ADDR_W'(cntInc);
          end
        end
        RUN: begin
          if (cnt == CNT_W'(RUN_LEN - 1)) begin
            state    <= SEND;
            cnt      <= '0;
            abValid0 <= 1'b0;
            abAddr0  <= '0;
            yzWe0    <= 1'b0;
            yzAddr0  <= '0;
            sendIdx  <= '0;
          end else begin
            cnt      <= cntInc;
            abValid0 <= (cntInc < CNT_W'(ARRAY_SIZE));
            abAddr0  <= (cntInc < CNT_W'(ARRAY_SIZE)) ? ADDR_W'(cntInc) : '0;
            yzWe0    <= yzIn;
            yzAddr0  <= yzIn ? ADDR_W'(yzOff) : '0;
          end
        end
        SEND: begin
          if (!m_tvalid) begin
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b0;
            sendIdx  <= '0;
          end else if (m_tready) begin
            if (m_tlast) begin
              state    <= IDLE;
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
              sendIdx  <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              sendIdx <= sendIdx + ADDR_W'(1);
              m_tlast <= ((sendIdx + ADDR_W'(1)) == LAST_IDX);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Per-line and per-column skew: slice k is slice 0 delayed k cycles.
  for (genvar k = 0; k < ARRAY_SIZE; k++) begin : gSkew
    if (k == 0) begin : gHead
      assign ab_valid[0]           = abValid0;
      assign ab_raddr[0 +: ADDR_W] = abAddr0;
      assign yz_we[0]              = yzWe0;
      assign yz_waddr[0 +: ADDR_W] = yzAddr0;
    end else begin : gTail
      sa_skew_line #(
        .DEPTH  (k),
        .ADDR_W (ADDR_W)
      ) uAbLine (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .inValid  (abValid0),
        .inAddr   (abAddr0),
        .outValid (ab_valid[k]),
        .outAddr  (ab_raddr[k*ADDR_W +: ADDR_W])
      );
      sa_skew_line #(
        .DEPTH  (k),
        .ADDR_W (ADDR_W)
      ) uYzCol (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .inValid  (yzWe0),
        .inAddr   (yzAddr0),
        .outValid (yz_we[k]),
        .outAddr  (yz_waddr[k*ADDR_W +: ADDR_W])
      );
    end
  end

endmodule

// File: tb/tb_sa_stream_ctrl.sv
// Self-checking bench for sa_stream_ctrl (N=4, ARRAY_LAT=8).
module tb_sa_stream_ctrl;

  localparam int unsigned N       = 4;
  localparam int unsigned LAT     = 8;
  localparam int unsigned AW      = 2;
  localparam int unsigned RUN_CYC = LAT + 2 * N - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            interrupt;
  logic            reuse_weights;
  logic            s_tvalid;
  logic            s_tlast;
  logic            s_tready;
  logic            m_tready;
  logic            m_tvalid;
  logic            m_tlast;
  logic            fill_we;
  logic [AW-1:0]   abc_waddr;
  logic            load_w;
  logic [AW-1:0]   c_raddr;
  logic [N-1:0]    ab_valid;
  logic [N*AW-1:0] ab_raddr;
  logic [N-1:0]    yz_we;
  logic [N*AW-1:0] yz_waddr;
  logic [AW-1:0]   yz_raddr;
  logic            busy;
  logic            done;
  logic            err_tlast;

  int total;
  int bad;
  bit wloadOkM;
  bit errM;

  logic [31:0] yzMem [N];
  logic [31:0] rdData;

  sa_stream_ctrl #(
    .ARRAY_SIZE (N),
    .ARRAY_LAT  (LAT),
    .ADDR_W     (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .interrupt     (interrupt),
    .reuse_weights (reuse_weights),
    .s_tvalid      (s_tvalid),
    .s_tlast       (s_tlast),
    .s_tready      (s_tready),
    .m_tready      (m_tready),
    .m_tvalid      (m_tvalid),
    .m_tlast       (m_tlast),
    .fill_we       (fill_we),
    .abc_waddr     (abc_waddr),
    .load_w        (load_w),
    .c_raddr       (c_raddr),
    .ab_valid      (ab_valid),
    .ab_raddr      (ab_raddr),
    .yz_we         (yz_we),
    .yz_waddr      (yz_waddr),
    .yz_raddr      (yz_raddr),
    .busy          (busy),
    .done          (done),
    .err_tlast     (err_tlast)
  );

  always #5 clk = ~clk;

  // Stand-in result memory: synchronous read, one cycle latency.
  always @(posedge clk) rdData <= yzMem[yz_raddr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic afterAbort();
    wloadOkM = 1'b0;
    chk("abort_idle", {busy, m_tvalid, m_tlast, s_tready, load_w, fill_we, ab_valid, yz_we}, '0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", {done, busy}, '0);
      tick();
    end
  endtask

  // One job: intrPhase 0=none, 1=during RUN cycle intrAt, 2=during SEND word intrAt.
  task automatic runJob(input bit reuse, input int errBeat, input bit gaps, input bit randReady,
                        input int stallWord, input int stallLen, input int intrPhase,
                        input int intrAt, input bit noisyStart);
    int b;
    int cyc;
    int w;
    int stalled;
    int idx;
    bit expLoad;
    bit v;
    bit lst;
    bit rdy;
    logic [N-1:0]    expV;
    logic [N*AW-1:0] expA;
    logic [N*AW-1:0] mask;
    logic [N-1:0]    expW;
    logic [N*AW-1:0] expWa;
    logic [N*AW-1:0] maskW;

    for (int i = 0; i < N; i++) yzMem[i] = $urandom;
    expLoad = !(reuse && wloadOkM);

    start = 1'b1;
    reuse_weights = reuse;
    tick();
    start = 1'b0;
    reuse_weights = 1'($urandom_range(0, 1));
    errM = 1'b0;
    chk("start_state", {busy, s_tready, load_w}, 3'b110);
    chk("start_errclr", err_tlast, errM);

    b = 0;
    cyc = 0;
    while (b < int'(N) && cyc < 200) begin
      v   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      lst = (errBeat >= 0) ? (b == errBeat) : (b == int'(N) - 1);
      s_tvalid = v;
      s_tlast  = lst;
      if (noisyStart) start = 1'($urandom_range(0, 1));
      #1;
      chk("fill_we", fill_we, v);
      chk("abc_waddr", abc_waddr, b);
      chk("fill_err", err_tlast, errM);
      tick();
      if (v) begin
        if (lst != (b == int'(N) - 1)) errM = 1'b1;
        b++;
      end
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (b < int'(N)) begin
      chk("fill_timeout", b, N);
      start = 1'b0;
      return;
    end
    chk("fill_exit", {s_tready, load_w, busy}, {1'b0, expLoad, 1'b1});
    chk("fill_err_end", err_tlast, errM);

    if (expLoad) begin
      for (int i = 0; i < int'(N); i++) begin
        chk("load_w", load_w, 1'b1);
        chk("c_raddr", c_raddr, i);
        if (noisyStart) start = 1'($urandom_range(0, 1));
        tick();
      end
      wloadOkM = 1'b1;
    end

    for (int r = 0; r < int'(RUN_CYC); r++) begin
      expV = '0; expA = '0; mask = '0;
      expW = '0; expWa = '0; maskW = '0;
      for (int k = 0; k < int'(N); k++) begin
        idx = r - k;
        if (idx >= 0 && idx < int'(N)) begin
          expV[k] = 1'b1;
          expA[k*AW +: AW] = AW'(idx);
          mask[k*AW +: AW] = '1;
        end
        idx = r - int'(LAT) - k;
        if (idx >= 0 && idx < int'(N)) begin
          expW[k] = 1'b1;
          expWa[k*AW +: AW] = AW'(idx);
          maskW[k*AW +: AW] = '1;
        end
      end
      chk("ab_valid", ab_valid, expV);
      chk("ab_raddr", ab_raddr & mask, expA);
      chk("yz_we", yz_we, expW);
      chk("yz_waddr", yz_waddr & maskW, expWa);
      chk("run_ctl", {busy, load_w, m_tvalid, s_tready}, 4'b1000);
      if (intrPhase == 1 && r == intrAt) begin
        interrupt = 1'b1;
        start = 1'b0;
        tick();
        interrupt = 1'b0;
        afterAbort();
        return;
      end
      if (noisyStart) start = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;

    chk("send_entry", {m_tvalid, busy, ab_valid, yz_we}, {2'b01, {(2*N){1'b0}}});
    chk("send_raddr0", yz_raddr, 0);
    tick();

    w = 0;
    stalled = 0;
    cyc = 0;
    while (w < int'(N) && cyc < 100) begin
      if (intrPhase == 2 && w == intrAt) begin
        interrupt = 1'b1;
        m_tready = 1'b0;
        tick();
        interrupt = 1'b0;
        afterAbort();
        return;
      end
      if (w == stallWord && stalled < stallLen) begin
        rdy = 1'b0;
        stalled++;
      end else begin
        rdy = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      m_tready = rdy;
      #1;
      chk("m_tvalid", m_tvalid, 1'b1);
      chk("m_tlast", m_tlast, (w == int'(N) - 1));
      chk("m_data", rdData, yzMem[w]);
      if (!(rdy && w == int'(N) - 1)) chk("yz_raddr", yz_raddr, rdy ? w + 1 : w);
      chk("send_no_done", done, 1'b0);
      tick();
      if (rdy) w++;
      cyc++;
    end
    m_tready = 1'b0;
    if (w < int'(N)) begin
      chk("send_timeout", w, N);
      return;
    end
    chk("done_pulse", {done, busy, m_tvalid, m_tlast}, 4'b1000);
    tick();
    chk("done_clear", {done, busy}, 2'b00);
    chk("err_sticky", err_tlast, errM);
  endtask

  initial begin
    int eb;
    rst = 1'b1;
    start = 1'b0;
    interrupt = 1'b0;
    reuse_weights = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b0;
    total = 0;
    bad = 0;
    wloadOkM = 1'b0;
    errM = 1'b0;
    for (int i = 0; i < int'(N); i++) yzMem[i] = '0;

    repeat (3) tick();
    chk("rst_ctl", {busy, done, err_tlast, s_tready, m_tvalid, m_tlast, load_w, fill_we}, '0);
    chk("rst_vec", {ab_valid, yz_we}, '0);
    chk("rst_addr", {abc_waddr, c_raddr, ab_raddr, yz_waddr, yz_raddr}, '0);
    rst = 1'b0;
    tick();
    chk("idle_ctl", {busy, done, s_tready, m_tvalid, load_w}, '0);

    // Baseline job with weight load.
    runJob(1'b0, -1, 1'b0, 1'b0, -1, 0, 0, 0, 1'b0);
    // Weights reused: FILL goes straight to RUN.
    runJob(1'b1, -1, 1'b0, 1'b0, -1, 0, 0, 0, 1'b0);
    // Abort in the middle of RUN.
    runJob(1'b1, -1, 1'b0, 1'b0, -1, 0, 1, 5, 1'b0);
    // Reuse requested after abort must reload; word 1 stalled for 3 cycles.
    runJob(1'b1, -1, 1'b0, 1'b0, 1, 3, 0, 0, 1'b0);
    // Early tlast on beat 1, input gaps, start noise while busy.
    runJob(1'b1, 1, 1'b1, 1'b0, -1, 0, 0, 0, 1'b1);
    repeat (3) begin
      chk("err_idle_hold", {err_tlast, busy}, 2'b10);
      tick();
    end
    // Abort in the middle of SEND.
    runJob(1'b0, -1, 1'b0, 1'b1, -1, 0, 2, 2, 1'b0);
    chk("err_after_abort", err_tlast, errM);
    // Randomized jobs.
    for (int j = 0; j < 6; j++) begin
      eb = int'($urandom_range(0, N));
      if (eb == int'(N)) eb = -1;
      runJob(1'($urandom_range(0, 1)), eb, 1'b1, 1'b1, int'($urandom_range(0, N - 1)),
             int'($urandom_range(0, 3)), 0, 0, 1'b1);
      repeat (int'($urandom_range(0, 2))) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
